// File: rtl/secure_serdes_encryptor_pkg.sv
// Shared types, default constants and the rotate helper for the serial byte encryptor.
package secure_serdes_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CALC  = 2'd2,
      TX    = 2'd3
   } state_t;

   localparam int unsigned DEF_WIDTH    = 8;
   localparam int unsigned DEF_ROT      = 3;
   localparam logic [7:0]  DEF_KEY_MASK = 8'hA5;

   // Widest word the rotate helper handles; callers truncate to their own width.
   localparam int unsigned ROTL_MAX = 64;

   // Rotate the low w bits of v left by r (modulo w); bits above w come back as 0.
   function automatic logic [ROTL_MAX-1:0] rotl(input logic [ROTL_MAX-1:0] v,
                                                 input int unsigned w,
                                                 input int unsigned r);
      logic [ROTL_MAX-1:0] res;
      logic [5:0]          src;
      logic [5:0]          dst;
      res = '0;
      for (int unsigned i = 0; i < ROTL_MAX; i++) begin
         if (i < w) begin
            src      = 6'(i);
            dst      = 6'((i + r) % w);
            res[dst] = v[src];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/secure_serdes_encryptor_if.sv
// Handshake/data bundle between a driver and the serial encryptor core.
interface secure_serdes_encryptor_if
   import secure_serdes_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);
   logic             ena;
   logic             start;
   logic             a_bit;
   logic             b_bit;
   logic [WIDTH-1:0] cipher;
   logic             done;
   logic             busy;
   logic             ser_out;
   logic             ser_valid;

   modport master (
      output ena, start, a_bit, b_bit,
      input  cipher, done, busy, ser_out, ser_valid
   );

   modport slave (
      input  ena, start, a_bit, b_bit,
      output cipher, done, busy, ser_out, ser_valid
   );
endinterface

// File: rtl/secure_serdes_encryptor_shift_reg.sv
// MSB-first serial-in/serial-out register with parallel load and shift enable.
module serdes_shift_reg
   import secure_serdes_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_ena,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic             i_shift,
   input  logic             i_ser_in,
   output logic [WIDTH-1:0] o_par,
   output logic             o_ser
);
   logic [WIDTH-1:0] r_sr;

   // Load wins over shift; everything holds while the clock enable is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr <= '0;
      end else if (i_ena) begin
         if (i_load) begin
            r_sr <= i_load_data;
         end else if (i_shift) begin
            r_sr <= {r_sr[WIDTH-2:0], i_ser_in};
         end
      end
   end

   assign o_par = r_sr;
   assign o_ser = r_sr[WIDTH-1];
endmodule

// File: rtl/secure_serdes_encryptor.sv
// Serial-in byte encryptor: captures A and B MSB-first, emits
// ROTL(A^B, ROT) ^ KEY_MASK. Define SERDES_SERIAL_TX_EN to add the TX state
// that re-serialises the cipher on ser_out/ser_valid.
module secure_serdes_encryptor
   import secure_serdes_pkg::*;
#(
   parameter int unsigned      WIDTH    = DEF_WIDTH,
   parameter int unsigned      ROT      = DEF_ROT,
   parameter logic [WIDTH-1:0] KEY_MASK = WIDTH'(DEF_KEY_MASK)
)(
   input logic                      clk,
   input logic                      rst,
   secure_serdes_encryptor_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_cipher;
   logic             r_done;

   logic             w_cap_shift;
   logic [WIDTH-1:0] w_a_par;
   logic [WIDTH-1:0] w_b_par;
   logic [WIDTH-1:0] w_result;
   logic             w_a_ser_unused;
   logic             w_b_ser_unused;

   assign w_cap_shift = (r_state == SHIFT);
   assign w_result    = WIDTH'(rotl(ROTL_MAX'(w_a_par ^ w_b_par), WIDTH, ROT)) ^ KEY_MASK;

   serdes_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
      .clk         (clk),
      .rst         (rst),
      .i_ena       (bus.ena),
      .i_load      (1'b0),
      .i_load_data ('0),
      .i_shift     (w_cap_shift),
      .i_ser_in    (bus.a_bit),
      .o_par       (w_a_par),
      .o_ser       (w_a_ser_unused)
   );

   serdes_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
      .clk         (clk),
      .rst         (rst),
      .i_ena       (bus.ena),
      .i_load      (1'b0),
      .i_load_data ('0),
      .i_shift     (w_cap_shift),
      .i_ser_in    (bus.b_bit),
      .o_par       (w_b_par),
      .o_ser       (w_b_ser_unused)
   );

`ifdef SERDES_SERIAL_TX_EN
   logic             r_ser_out;
   logic             r_ser_valid;
   logic             w_tx_load;
   logic             w_tx_shift;
   logic             w_tx_ser;
   logic [WIDTH-1:0] w_tx_par_unused;

   // The TX register is loaded with the same value CALC writes to cipher, so
   // it is ready to shift on the first TX edge.
   assign w_tx_load  = (r_state == CALC);
   assign w_tx_shift = (r_state == TX) && (r_cnt != CW'(WIDTH));

   serdes_shift_reg #(.WIDTH(WIDTH)) u_tx_sr (
      .clk         (clk),
      .rst         (rst),
      .i_ena       (bus.ena),
      .i_load      (w_tx_load),
      .i_load_data (w_result),
      .i_shift     (w_tx_shift),
      .i_ser_in    (1'b0),
      .o_par       (w_tx_par_unused),
      .o_ser       (w_tx_ser)
   );

   assign bus.ser_out   = r_ser_out;
   assign bus.ser_valid = r_ser_valid;
`else
   assign bus.ser_out   = 1'b0;
   assign bus.ser_valid = 1'b0;
`endif

   // Control FSM with registered result/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_cipher <= '0;
         r_done   <= 1'b0;
`ifdef SERDES_SERIAL_TX_EN
         r_ser_out   <= 1'b0;
         r_ser_valid <= 1'b0;
`endif
      end else if (bus.ena) begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_state <= SHIFT;
                  r_cnt   <= '0;
                  r_done  <= 1'b0;
               end
            end
            SHIFT: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_cipher <= w_result;
               r_done   <= 1'b1;
               r_cnt    <= '0;
`ifdef SERDES_SERIAL_TX_EN
               r_state  <= TX;
`else
               r_state  <= IDLE;
`endif
            end
`ifdef SERDES_SERIAL_TX_EN
            // WIDTH bit-present edges, then one edge to drop ser_valid.
            TX: begin
               if (r_cnt == CW'(WIDTH)) begin
                  r_ser_out   <= 1'b0;
                  r_ser_valid <= 1'b0;
                  r_state     <= IDLE;
               end else begin
                  r_ser_out   <= w_tx_ser;
                  r_ser_valid <= 1'b1;
                  r_cnt       <= r_cnt + CW'(1);
               end
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.cipher = r_cipher;
   assign bus.done   = r_done;
   assign bus.busy   = (r_state != IDLE);
endmodule

// File: tb/tb_secure_serdes_encryptor.sv
// Scoreboard bench for secure_serdes_encryptor (default 8-bit, ROT=3, mask A5).
module tb_secure_serdes_encryptor;
   import secure_serdes_pkg::*;

   localparam int         W    = 8;
   localparam int         R    = 3;
   localparam logic [7:0] MASK = 8'hA5;
`ifdef SERDES_SERIAL_TX_EN
   localparam int TX_TAIL = W + 1;
`else
   localparam int TX_TAIL = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   secure_serdes_encryptor_if #(.WIDTH(W)) bus ();

   secure_serdes_encryptor #(.WIDTH(W), .ROT(R), .KEY_MASK(MASK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] tx_q[$];

   logic       prev_done = 1'b0;
   logic       prev_sv   = 1'b0;
   logic [7:0] tx_bits   = '0;
   int         tx_n      = 0;
   logic       ser_seen  = 1'b0;

   logic [7:0] ra;
   logic [7:0] rb;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] d;
      d = {a ^ b, a ^ b} >> (W - R);
      return d[7:0] ^ MASK;
   endfunction

   // Result monitor: each rising edge of done pops one expected cipher.
   always @(negedge clk) begin
      if (bus.done && !prev_done) begin
         if (exp_q.size() == 0) check_eq("spurious_done", 1, 0);
         else                   check_eq("cipher", bus.cipher, exp_q.pop_front());
      end
      prev_done <= bus.done;
`ifdef SERDES_SERIAL_TX_EN
      if (bus.ser_valid) begin
         tx_bits <= {tx_bits[6:0], bus.ser_out};
         tx_n    <= tx_n + 1;
      end else if (prev_sv) begin
         check_eq("ser_len", tx_n, W);
         if (tx_q.size() == 0) check_eq("spurious_ser", 1, 0);
         else                  check_eq("ser_byte", tx_bits, tx_q.pop_front());
         tx_n <= 0;
      end
      prev_sv <= bus.ser_valid;
`else
      if (bus.ser_valid || bus.ser_out) ser_seen <= 1'b1;
`endif
   end

   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                          input int stall_bit, input int extra_bit);
      int k;
      exp_q.push_back(exp);
`ifdef SERDES_SERIAL_TX_EN
      tx_q.push_back(exp);
`endif
      @(posedge clk); #1; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      check_eq("busy_t0", bus.busy, 1);
      for (int i = W - 1; i >= 0; i--) begin
         bus.a_bit = a[i];
         bus.b_bit = b[i];
         if (i == stall_bit) begin
            bus.ena = 1'b0;
            repeat (3) @(posedge clk);
            #1; bus.ena = 1'b1;
         end
         bus.start = (i == extra_bit);
         @(posedge clk); #1;
         if (i == extra_bit) check_eq("busy_extra", bus.busy, 1);
      end
      bus.start = 1'b0;
      bus.a_bit = 1'b0;
      bus.b_bit = 1'b0;
      check_eq("done_t8", bus.done, 0);
      @(posedge clk); #1;
      check_eq("done_t9", bus.done, 1);
      k = 0;
      while (bus.busy && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      check_eq("busy_tail", k, TX_TAIL);
      @(negedge clk); #1;
      check_eq("sb_empty", exp_q.size(), 0);
      check_eq("tx_empty", tx_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ena   = 1'b1;
      bus.start = 1'b0;
      bus.a_bit = 1'b0;
      bus.b_bit = 1'b0;
      rst       = 1'b1;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      check_eq("rst_cipher", bus.cipher, 0);
      check_eq("rst_done", bus.done, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_ser_out", bus.ser_out, 0);
      check_eq("rst_ser_valid", bus.ser_valid, 0);

      run_txn(8'h02, 8'h03, 8'hAD, -1, -1);
      run_txn(8'hC3, 8'h5A, 8'h69, -1, 3);
      run_txn(8'hFF, 8'h00, 8'h5A, -1, -1);

      // Abort during SHIFT after four bits have been captured.
      @(posedge clk); #1; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      for (int i = W - 1; i >= 4; i--) begin
         bus.a_bit = 1'b1;
         bus.b_bit = 1'b0;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort_busy", bus.busy, 0);
      check_eq("abort_done", bus.done, 0);
      check_eq("abort_cipher", bus.cipher, 0);
      repeat (12) @(posedge clk);
      #1;
      check_eq("abort_no_done", bus.done, 0);

      run_txn(8'h02, 8'h03, 8'hAD, 4, -1);

      for (int n = 0; n < 3; n++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run_txn(ra, rb, model(ra, rb), -1, -1);
      end

`ifndef SERDES_SERIAL_TX_EN
      check_eq("ser_quiet", ser_seen, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
